// File: rtl/avalon_fast_serial_mem_arbiter.sv
// Two-port Avalon-MM arbiter in front of the single-port 1024x32 on-chip RAM.
// Port A is the fast-serial bridge master, port B the processor data master.
// Per-cycle round-robin grant, fixed one-cycle read latency with per-port
// readdatavalid. Define AFS_MEM_ARB_FIXED_PRIO_EN to give port A absolute
// priority on contention (B may starve).
module avalon_fast_serial_mem_arbiter #(
  parameter  int unsigned ADDR_W = 10,
  parameter  int unsigned DATA_W = 32,
  localparam int unsigned BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] a_address,
  input  logic [BE_W-1:0]   a_byteenable,
  input  logic              a_read,
  input  logic              a_write,
  input  logic [DATA_W-1:0] a_writedata,
  output logic              a_waitrequest,
  output logic              a_readdatavalid,
  output logic [DATA_W-1:0] a_readdata,
  input  logic [ADDR_W-1:0] b_address,
  input  logic [BE_W-1:0]   b_byteenable,
  input  logic              b_read,
  input  logic              b_write,
  input  logic [DATA_W-1:0] b_writedata,
  output logic              b_waitrequest,
  output logic              b_readdatavalid,
  output logic [DATA_W-1:0] b_readdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic              mem_debugaccess,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata
);

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  logic  r_rd_pend;
  port_e r_rd_owner;

  logic  w_req_a;
  logic  w_req_b;
  logic  w_grant_a;
  logic  w_grant_b;
  logic  w_accept;
  logic  w_wr;
  logic  w_rd_accept;

  assign w_req_a = a_read | a_write;
  assign w_req_b = b_read | b_write;

`ifdef AFS_MEM_ARB_FIXED_PRIO_EN
  // Fixed priority: A wins whenever it requests; nothing granted in reset
  always_comb begin
    w_grant_a = 1'b0;
    w_grant_b = 1'b0;
    if (reset_n) begin
      w_grant_a = w_req_a;
      w_grant_b = w_req_b & ~w_req_a;
    end
  end
`else
  port_e r_last_grant;

  // Round-robin: a lone requester wins; on contention the port that did not win last time wins
  always_comb begin
    w_grant_a = 1'b0;
    w_grant_b = 1'b0;
    if (reset_n) begin
      if (w_req_a && w_req_b) begin
        if (r_last_grant == PORT_B) w_grant_a = 1'b1;
        else                        w_grant_b = 1'b1;
      end else begin
        w_grant_a = w_req_a;
        w_grant_b = w_req_b;
      end
    end
  end

  // Remember the most recent winner; reset value makes A win the first contention
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant <= PORT_B;
    end else if (w_accept) begin
      r_last_grant <= w_grant_b ? PORT_B : PORT_A;
    end
  end
`endif

  assign w_accept = w_grant_a | w_grant_b;

  // Waitrequest is forced high during reset; otherwise only a losing requester waits
  assign a_waitrequest = ~reset_n | (w_req_a & ~w_grant_a);
  assign b_waitrequest = ~reset_n | (w_req_b & ~w_grant_b);

  // A write request takes precedence over a simultaneous read on the same port
  always_comb begin
    w_wr        = 1'b0;
    w_rd_accept = 1'b0;
    if (w_grant_a) begin
      w_wr        = a_write;
      w_rd_accept = a_read & ~a_write;
    end else if (w_grant_b) begin
      w_wr        = b_write;
      w_rd_accept = b_read & ~b_write;
    end
  end

  // Winner's address/data steer the RAM; port A values sit on the bus when idle
  always_comb begin
    mem_address    = a_address;
    mem_byteenable = a_byteenable;
    mem_writedata  = a_writedata;
    if (w_grant_b) begin
      mem_address    = b_address;
      mem_byteenable = b_byteenable;
      mem_writedata  = b_writedata;
    end
  end

  assign mem_chipselect  = w_accept;
  assign mem_write       = w_wr;
  assign mem_debugaccess = w_wr;

  // Single-entry read tag, overwritten every cycle; RAM latency is exactly one cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_pend  <= 1'b0;
      r_rd_owner <= PORT_A;
    end else begin
      r_rd_pend <= w_rd_accept;
      if (w_rd_accept) r_rd_owner <= w_grant_b ? PORT_B : PORT_A;
    end
  end

  assign a_readdatavalid = r_rd_pend & (r_rd_owner == PORT_A);
  assign b_readdatavalid = r_rd_pend & (r_rd_owner == PORT_B);
  assign a_readdata      = mem_readdata;
  assign b_readdata      = mem_readdata;

endmodule

// File: tb/tb_avalon_fast_serial_mem_arbiter.sv
// Bench for avalon_fast_serial_mem_arbiter: directed scenarios followed by
// random traffic, checked against a transaction-level model of the arbiter
// and RAM. Honours AFS_MEM_ARB_FIXED_PRIO_EN when defined.
module tb_avalon_fast_serial_mem_arbiter;

  logic        clk;
  logic        reset_n;
  logic [9:0]  a_address, b_address;
  logic [3:0]  a_byteenable, b_byteenable;
  logic        a_read, a_write, b_read, b_write;
  logic [31:0] a_writedata, b_writedata;
  logic        a_waitrequest, b_waitrequest;
  logic        a_readdatavalid, b_readdatavalid;
  logic [31:0] a_readdata, b_readdata;
  logic [9:0]  mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_debugaccess;
  logic [31:0] mem_writedata, mem_readdata;

  avalon_fast_serial_mem_arbiter #(.ADDR_W(10), .DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_address(a_address), .a_byteenable(a_byteenable), .a_read(a_read),
    .a_write(a_write), .a_writedata(a_writedata), .a_waitrequest(a_waitrequest),
    .a_readdatavalid(a_readdatavalid), .a_readdata(a_readdata),
    .b_address(b_address), .b_byteenable(b_byteenable), .b_read(b_read),
    .b_write(b_write), .b_writedata(b_writedata), .b_waitrequest(b_waitrequest),
    .b_readdatavalid(b_readdatavalid), .b_readdata(b_readdata),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_debugaccess(mem_debugaccess), .mem_writedata(mem_writedata),
    .mem_readdata(mem_readdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // On-chip RAM: registered address, unregistered data out, write needs debugaccess
  logic [31:0] ram [1024];
  logic [9:0]  ram_addr;
  always @(posedge clk) begin
    if (mem_chipselect) begin
      ram_addr <= mem_address;
      if (mem_write && mem_debugaccess)
        for (int i = 0; i < 4; i++)
          if (mem_byteenable[i]) ram[mem_address][8*i +: 8] <= mem_writedata[8*i +: 8];
    end
  end
  assign mem_readdata = ram[ram_addr];

  // Transaction-level reference state
  logic [31:0] m_mem [1024];
  int          m_last;     // 0 = A won last, 1 = B won last
  bit          m_pend;
  int          m_owner;
  logic [9:0]  m_pend_addr;
  bit          rst_drive;
  int          total, bad;
  int          grants_a, grants_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive at negedge, check mid-cycle, advance the model at posedge
  task automatic step(input logic ar, input logic aw, input logic [9:0] aa,
                      input logic [3:0] abe, input logic [31:0] awd,
                      input logic br, input logic bw, input logic [9:0] ba,
                      input logic [3:0] bbe, input logic [31:0] bwd);
    bit ra, rb, ga, gb, acc, wr, rd;
    logic [9:0]  ea;
    logic [3:0]  ebe;
    logic [31:0] ewd;
    @(negedge clk);
    reset_n = rst_drive;
    a_read = ar; a_write = aw; a_address = aa; a_byteenable = abe; a_writedata = awd;
    b_read = br; b_write = bw; b_address = ba; b_byteenable = bbe; b_writedata = bwd;
    #1;
    if (!reset_n) begin
      m_pend = 0;
      m_last = 1;
    end
    ra = ar | aw;
    rb = br | bw;
    ga = 0; gb = 0;
    if (reset_n) begin
      if (ra && rb) begin
`ifdef AFS_MEM_ARB_FIXED_PRIO_EN
        ga = 1;
`else
        ga = (m_last == 1);
        gb = !ga;
`endif
      end else begin
        ga = ra;
        gb = rb;
      end
    end
    acc = ga | gb;
    wr  = ga ? aw : (gb ? bw : 1'b0);
    rd  = acc && !wr && (ga ? ar : br);
    ea  = gb ? ba  : aa;
    ebe = gb ? bbe : abe;
    ewd = gb ? bwd : awd;
    chk("a_waitrequest", 32'(a_waitrequest), 32'(!reset_n || (ra && !ga)));
    chk("b_waitrequest", 32'(b_waitrequest), 32'(!reset_n || (rb && !gb)));
    chk("mem_chipselect", 32'(mem_chipselect), 32'(acc));
    chk("mem_write", 32'(mem_write), 32'(wr));
    chk("mem_debugaccess", 32'(mem_debugaccess), 32'(wr));
    chk("mem_address", 32'(mem_address), 32'(ea));
    chk("mem_byteenable", 32'(mem_byteenable), 32'(ebe));
    chk("mem_writedata", mem_writedata, ewd);
    chk("a_readdatavalid", 32'(a_readdatavalid), 32'(m_pend && m_owner == 0));
    chk("b_readdatavalid", 32'(b_readdatavalid), 32'(m_pend && m_owner == 1));
    if (m_pend && m_owner == 0) chk("a_readdata", a_readdata, m_mem[m_pend_addr]);
    if (m_pend && m_owner == 1) chk("b_readdata", b_readdata, m_mem[m_pend_addr]);
    @(posedge clk);
    if (ga) grants_a++;
    if (gb) grants_b++;
    if (acc) m_last = gb ? 1 : 0;
    if (wr)
      for (int i = 0; i < 4; i++)
        if (ebe[i]) m_mem[ea][8*i +: 8] = ewd[8*i +: 8];
    m_pend = rd;
    if (rd) begin
      m_owner     = gb ? 1 : 0;
      m_pend_addr = ea;
    end
  endtask

  task automatic idle();
    step(0, 0, 10'h0, 4'h0, 32'h0, 0, 0, 10'h0, 4'h0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    total = 0; bad = 0; grants_a = 0; grants_b = 0;
    for (int i = 0; i < 1024; i++) begin
      ram[i]   = 32'h1000_0000 + 32'(i);
      m_mem[i] = 32'h1000_0000 + 32'(i);
    end
    ram_addr = '0;
    m_pend = 0; m_last = 1; m_owner = 0; m_pend_addr = '0;
    reset_n = 1'b0; rst_drive = 1'b0;
    a_read = 0; a_write = 0; a_address = '0; a_byteenable = '0; a_writedata = '0;
    b_read = 0; b_write = 0; b_address = '0; b_byteenable = '0; b_writedata = '0;

    // Held in reset with both ports requesting
    step(1, 0, 10'h010, 4'hF, 32'h0, 1, 0, 10'h020, 4'hF, 32'h0);
    step(1, 0, 10'h010, 4'hF, 32'h0, 1, 0, 10'h020, 4'hF, 32'h0);
    // Release: A wins the first contended edge
    rst_drive = 1'b1;
    grants_a = 0; grants_b = 0;
    step(1, 0, 10'h010, 4'hF, 32'h0, 1, 0, 10'h020, 4'hF, 32'h0);
    chk("first_grant_is_a", 32'(grants_a), 32'd1);
    idle();

    // Single-port write then read
    step(0, 1, 10'h155, 4'hF, 32'hDEADBEEF, 0, 0, 10'h0, 4'h0, 32'h0);
    step(1, 0, 10'h155, 4'hF, 32'h0, 0, 0, 10'h0, 4'h0, 32'h0);
    idle();
    chk("model_deadbeef", m_mem[10'h155], 32'hDEADBEEF);

    // Byte-lane merge
    step(0, 1, 10'h007, 4'hF, 32'h11223344, 0, 0, 10'h0, 4'h0, 32'h0);
    step(0, 1, 10'h007, 4'h5, 32'hAABBCCDD, 0, 0, 10'h0, 4'h0, 32'h0);
    step(1, 0, 10'h007, 4'hF, 32'h0, 0, 0, 10'h0, 4'h0, 32'h0);
    idle();
    chk("model_bytelanes", m_mem[10'h007], 32'h11BB33DD);

    // Sustained contention, six cycles of reads from both ports
    grants_a = 0; grants_b = 0;
    for (int i = 0; i < 6; i++)
      step(1, 0, 10'h155, 4'hF, 32'h0, 1, 0, 10'h007, 4'hF, 32'h0);
    idle();
`ifdef AFS_MEM_ARB_FIXED_PRIO_EN
    chk("contention_grants_a", 32'(grants_a), 32'd6);
`else
    chk("contention_grants_a", 32'(grants_a), 32'd3);
    chk("contention_grants_b", 32'(grants_b), 32'd3);
`endif

    // Reset asserted the cycle after a read accept drops the read
    step(1, 0, 10'h155, 4'hF, 32'h0, 0, 0, 10'h0, 4'h0, 32'h0);
    rst_drive = 1'b0;
    step(0, 0, 10'h0, 4'h0, 32'h0, 0, 0, 10'h0, 4'h0, 32'h0);
    rst_drive = 1'b1;
    idle();

    // Read and write together on A: write wins, no readdatavalid
    step(1, 1, 10'h003, 4'hF, 32'h00000005, 0, 0, 10'h0, 4'h0, 32'h0);
    idle();
    step(1, 0, 10'h003, 4'hF, 32'h0, 0, 0, 10'h0, 4'h0, 32'h0);
    idle();
    chk("model_rw_addr3", m_mem[10'h003], 32'h00000005);

    // Random mixed traffic on a small address window
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)),
           4'($urandom), $urandom,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)),
           4'($urandom), $urandom);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
